regression_controller: RTL and testbench

- FSM that sequences the linear-regression coefficient datapath over an N-sample data set.
- Generates sample addresses for the x/y sample memory.
- Drives every datapath control line: mean_en, rst_temps, rst_means, load_temps, load_mean_x, load_mean_y, select_150, select_y.
- Pass 1 computes means; pass 2 accumulates Sxx/Sxy; beta0/beta1 are then held valid with a start/busy/done handshake to the host.

---
 rtl/regression_controller.sv | 157 +++++++++++++++
 tb/tb_regression_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regression_controller.sv
// regression_controller: sequences the linear-regression coefficient datapath.
// Pass 1 accumulates raw x/y to form the means, pass 2 accumulates the
// products for Sxx/Sxy, then the result is held with done until restarted.
// Optional feature macro: REGRESSION_CTRL_ABORT_EN adds an abort input that
// returns any busy state to IDLE.
module regression_controller #(
   parameter int unsigned N      = 150,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
`ifdef REGRESSION_CTRL_ABORT_EN
   input  logic              abort,
`endif
   output logic [ADDR_W-1:0] addr,
   output logic              mean_en,
   output logic              rst_temps,
   output logic              rst_means,
   output logic              load_temps,
   output logic              load_mean_x,
   output logic              load_mean_y,
   output logic              select_150,
   output logic              select_y,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      StIdle,
      StInit,
      StSum,
      StMeanX,
      StMeanY,
      StClr,
      StSsum,
      StDone
   } state_t;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic              in_busy;

   // IDLE and DONE are the only states where the host owns the datapath.
   assign in_busy = (state_q != StIdle) && (state_q != StDone);

   // State and sample-index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         index_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   // Next-state and index sequencing; start is only honoured when not busy.
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StInit;
               index_d = '0;
            end
         end
         StInit: begin
            state_d = StSum;
            index_d = '0;
         end
         StSum: begin
            if (index_q == LastIdx) begin
               index_d = '0;
               state_d = StMeanX;
            end else begin
               index_d = index_q + 1'b1;
            end
         end
         StMeanX: state_d = StMeanY;
         StMeanY: state_d = StClr;
         StClr:   state_d = StSsum;
         StSsum: begin
            if (index_q == LastIdx) begin
               index_d = '0;
               state_d = StDone;
            end else begin
               index_d = index_q + 1'b1;
            end
         end
         StDone: begin
            if (start) begin
               state_d = StInit;
               index_d = '0;
            end
         end
         default: begin
            state_d = StIdle;
            index_d = '0;
         end
      endcase
`ifdef REGRESSION_CTRL_ABORT_EN
      // Abort overrides every normal transition while a regression runs.
      if (abort && in_busy) begin
         state_d = StIdle;
         index_d = '0;
      end
`endif
   end

   // Moore output decode from state plus index.
   always_comb begin
      addr        = index_q;
      mean_en     = 1'b0;
      rst_temps   = 1'b0;
      rst_means   = 1'b0;
      load_temps  = 1'b0;
      load_mean_x = 1'b0;
      load_mean_y = 1'b0;
      select_150  = 1'b0;
      select_y    = 1'b0;
      busy        = in_busy;
      done        = 1'b0;
      unique case (state_q)
         StIdle: ;
         StInit: begin
            rst_temps = 1'b1;
            rst_means = 1'b1;
         end
         StSum: begin
            mean_en    = 1'b1;
            load_temps = 1'b1;
         end
         StMeanX: begin
            select_150  = 1'b1;
            load_mean_x = 1'b1;
         end
         StMeanY: begin
            select_150  = 1'b1;
            select_y    = 1'b1;
            load_mean_y = 1'b1;
         end
         StClr: rst_temps = 1'b1;
         StSsum: load_temps = 1'b1;
         StDone: begin
            // Keep the dividend on the y accumulator so beta outputs stay stable.
            select_y = 1'b1;
            done     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_regression_controller.sv
// Bench for regression_controller: an N=4 instance checked cycle by cycle
// against a queue of expected control vectors, plus an N=150 instance for
// asynchronous reset, ignored start pulses and end-to-end latency.
module tb_regression_controller;

   localparam logic [9:0] VInit  = 10'b0110000010;
   localparam logic [9:0] VSum   = 10'b1001000010;
   localparam logic [9:0] VMeanX = 10'b0000101010;
   localparam logic [9:0] VMeanY = 10'b0000011110;
   localparam logic [9:0] VClr   = 10'b0100000010;
   localparam logic [9:0] VSsum  = 10'b0001000010;
   localparam logic [9:0] VDone  = 10'b0000000101;

   logic clk = 1'b0;
   logic rst;
   logic start4, start150;
   logic abort4, abort150;

   logic [7:0] addr4, addr150;
   logic me4, rt4, rm4, lt4, lmx4, lmy4, s4, sy4, busy4, done4;
   logic me1, rt1, rm1, lt1, lmx1, lmy1, s1, sy1, busy1, done1;
   logic [17:0] v4, v150;

   int n_assert = 0;
   int n_fail   = 0;

   logic [17:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   regression_controller #(.N(4), .ADDR_W(8)) dut4 (
      .clk(clk), .rst(rst), .start(start4),
`ifdef REGRESSION_CTRL_ABORT_EN
      .abort(abort4),
`endif
      .addr(addr4), .mean_en(me4), .rst_temps(rt4), .rst_means(rm4),
      .load_temps(lt4), .load_mean_x(lmx4), .load_mean_y(lmy4),
      .select_150(s4), .select_y(sy4), .busy(busy4), .done(done4)
   );

   regression_controller #(.N(150), .ADDR_W(8)) dut150 (
      .clk(clk), .rst(rst), .start(start150),
`ifdef REGRESSION_CTRL_ABORT_EN
      .abort(abort150),
`endif
      .addr(addr150), .mean_en(me1), .rst_temps(rt1), .rst_means(rm1),
      .load_temps(lt1), .load_mean_x(lmx1), .load_mean_y(lmy1),
      .select_150(s1), .select_y(sy1), .busy(busy1), .done(done1)
   );

   assign v4   = {addr4, me4, rt4, rm4, lt4, lmx4, lmy4, s4, sy4, busy4, done4};
   assign v150 = {addr150, me1, rt1, rm1, lt1, lmx1, lmy1, s1, sy1, busy1, done1};

   task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic push(input string tag, input logic [7:0] a, input logic [9:0] c);
      exp_q.push_back({a, c});
      tag_q.push_back(tag);
   endtask

   // Expected N=4 sequence starting with the cycle after the start edge.
   task automatic push_seq4(input int hold);
      push("init", 8'd0, VInit);
      for (int i = 0; i < 4; i++) push($sformatf("sum%0d", i), 8'(i), VSum);
      push("mean_x", 8'd0, VMeanX);
      push("mean_y", 8'd0, VMeanY);
      push("clr", 8'd0, VClr);
      for (int i = 0; i < 4; i++) push($sformatf("ssum%0d", i), 8'(i), VSsum);
      for (int i = 0; i <= hold; i++) push($sformatf("done%0d", i), 8'd0, VDone);
   endtask

   // Drive start, then pop one expectation per clock; pk1/pk2 pulse start mid-run.
   task automatic run4(input string name, input int pk1, input int pk2);
      int k;
      push_seq4(2);
      start4 = 1'b1;
      k = 0;
      while (exp_q.size() > 0) begin
         @(posedge clk);
         #1;
         check({name, "/", tag_q.pop_front()}, v4, exp_q.pop_front());
         start4 = (k == pk1) || (k == pk2);
         k++;
      end
      start4 = 1'b0;
   endtask

   initial begin
      int e;
      int max_addr;
      rst      = 1'b1;
      start4   = 1'b0;
      start150 = 1'b0;
      abort4   = 1'b0;
      abort150 = 1'b0;
      #1;
      check("reset_n4", v4, 18'd0);
      check("reset_n150", v150, 18'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_n4", v4, 18'd0);

      // Plain N=4 run, then start pulses in SUM and SSUM, then restart from DONE.
      run4("seq", -1, -1);
      run4("busy_start", 2, 9);
      run4("restart", -1, -1);

`ifdef REGRESSION_CTRL_ABORT_EN
      // Abort during SSUM index 1: IDLE next cycle, done never appears.
      start4 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         start4 = 1'b0;
      end
      check("pre_abort", v4, {8'd1, VSsum});
      abort4 = 1'b1;
      @(posedge clk);
      #1;
      abort4 = 1'b0;
      check("abort_idle", v4, 18'd0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", v4, 18'd0);
      run4("after_abort", -1, -1);
`endif

      // Asynchronous reset mid-SUM at index 37 on the N=150 instance.
      start150 = 1'b1;
      e = 0;
      do begin
         @(posedge clk);
         #1;
         start150 = 1'b0;
         e++;
      end while (addr150 != 8'd37 && e < 100);
      check("reach_idx37", {10'd0, addr150}, 18'd37);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_n150", v150, 18'd0);
      check("async_rst_n4", v4, 18'd0);
      @(negedge clk);
      rst = 1'b0;

      // Full N=150 run with ignored start pulses; done must rise on edge E0+304.
      @(posedge clk);
      #1;
      start150 = 1'b1;
      @(posedge clk);
      #1;
      start150 = 1'b0;
      check("n150_init", v150, {8'd0, VInit});
      e = 0;
      max_addr = 0;
      while (!done1 && e < 400) begin
         @(posedge clk);
         #1;
         e++;
         if (int'(addr150) > max_addr) max_addr = int'(addr150);
         start150 = (e == 50) || (e == 200);
      end
      start150 = 1'b0;
      check("n150_latency", 18'(e), 18'd304);
      check("n150_max_addr", 18'(max_addr), 18'd149);
      check("n150_done", v150, {8'd0, VDone});
      repeat (20) @(posedge clk);
      #1;
      check("n150_done_held", v150, {8'd0, VDone});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
